// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-ported register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int N_RD_DEF   = 2;
    localparam int N_WR_DEF   = 2;

    // Upper bounds for get_field; flattened buses and fields must fit inside them.
    localparam int FLAT_MAX_W  = 2048;
    localparam int FIELD_MAX_W = 64;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_e;

    function automatic logic [FIELD_MAX_W-1:0] get_field(
        input logic [FLAT_MAX_W-1:0] vec,
        input int                    idx,
        input int                    w
    );
        return FIELD_MAX_W'(vec >> (idx * w));
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-side bus of the register file: clear request, read and write ports.
interface regfile_mp_if #(
    parameter int DATA_W = regfile_pkg::DATA_W_DEF,
    parameter int ADDR_W = regfile_pkg::ADDR_W_DEF,
    parameter int N_RD   = regfile_pkg::N_RD_DEF,
    parameter int N_WR   = regfile_pkg::N_WR_DEF
);
    logic                   clear_req;
    logic                   ready;
    logic [N_RD*ADDR_W-1:0] rd_addr;
    logic [N_RD*DATA_W-1:0] rd_data;
    logic [N_WR-1:0]        wr_en;
    logic [N_WR*ADDR_W-1:0] wr_addr;
    logic [N_WR*DATA_W-1:0] wr_data;

    modport master (
        output clear_req, rd_addr, wr_en, wr_addr, wr_data,
        input  ready, rd_data
    );

    modport slave (
        input  clear_req, rd_addr, wr_en, wr_addr, wr_data,
        output ready, rd_data
    );
endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: sweeps every register to zero after reset or on clear_req.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req_i,
    output logic              ready_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            CLEAR: begin
                if (clear_req_i) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
                end
            end
            IDLE: begin
                if (clear_req_i) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    assign ready_o    = (state_q == IDLE);
    assign clr_we_o   = (state_q == CLEAR);
    assign clr_addr_o = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file, reg0 hardwired to zero, hardware clear sweep.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int N_RD   = N_RD_DEF,
    parameter int N_WR   = N_WR_DEF
) (
    input  logic          clk,
    input  logic          reset,
    regfile_mp_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic              ready;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wa    [N_WR];
    logic [DATA_W-1:0] wd    [N_WR];
    logic [ADDR_W-1:0] ra    [N_RD];
    logic [DATA_W-1:0] rd_a  [N_RD];

    regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
        .clk         (clk),
        .reset       (reset),
        .clear_req_i (bus.clear_req),
        .ready_o     (ready),
        .clr_we_o    (clr_we),
        .clr_addr_o  (clr_addr)
    );

    assign bus.ready = ready;

    always_comb begin
        for (int p = 0; p < N_WR; p++) begin
            wa[p] = ADDR_W'(get_field(FLAT_MAX_W'(bus.wr_addr), p, ADDR_W));
            wd[p] = DATA_W'(get_field(FLAT_MAX_W'(bus.wr_data), p, DATA_W));
        end
        for (int i = 0; i < N_RD; i++) begin
            ra[i] = ADDR_W'(get_field(FLAT_MAX_W'(bus.rd_addr), i, ADDR_W));
        end
    end

    // A clear request or reset in IDLE discards that cycle's writes.
    assign wr_ok = ready & ~bus.clear_req & ~reset;

    // NOTE: the array has no reset branch; the clear sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_ok) begin
            // Later ports overwrite earlier ones, so the highest index wins.
            for (int p = 0; p < N_WR; p++) begin
                if (bus.wr_en[p] && wa[p] != '0) mem_q[wa[p]] <= wd[p];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_RD; i++) begin
            rd_a[i] = '0;
            if (ready && ra[i] != '0) begin
                rd_a[i] = mem_q[ra[i]];
`ifdef REGFILE_BYPASS_EN
                for (int p = 0; p < N_WR; p++) begin
                    if (bus.wr_en[p] && wa[p] != '0 && wa[p] == ra[i]) rd_a[i] = wd[p];
                end
`endif
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < N_RD; i++) begin
            bus.rd_data[i*DATA_W +: DATA_W] = rd_a[i];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_regfile_mp;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int N_RD   = 2;
    localparam int N_WR   = 2;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic clk = 1'b0;
    logic reset;

    regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD), .N_WR(N_WR)) bus ();

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD), .N_WR(N_WR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_left = edges remaining until the array is usable again; whole array zero when it hits 0.
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_left  = 0;
    bit                m_valid = 1'b0;

    function automatic logic [ADDR_W-1:0] w_addr(input int p);
        return bus.wr_addr[p*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [DATA_W-1:0] w_data(input int p);
        return bus.wr_data[p*DATA_W +: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] rd(input int i);
        return bus.rd_data[i*DATA_W +: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] exp_rd(input int i);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] v;
        a = bus.rd_addr[i*ADDR_W +: ADDR_W];
        if (m_left != 0 || a == 0) return '0;
        v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < N_WR; p++)
            if (bus.wr_en[p] && w_addr(p) != 0 && w_addr(p) == a) v = w_data(p);
`endif
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_left  <= DEPTH;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            if (bus.clear_req) begin
                m_left <= DEPTH;
            end else if (m_left > 1) begin
                m_left <= m_left - 1;
            end else if (m_left == 1) begin
                m_left <= 0;
                for (int a = 0; a < DEPTH; a++) m_mem[a] <= '0;
            end else begin
                for (int p = 0; p < N_WR; p++)
                    if (bus.wr_en[p] && w_addr(p) != 0) m_mem[w_addr(p)] <= w_data(p);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("ready", {63'd0, bus.ready}, {63'd0, (m_left == 0)});
            for (int i = 0; i < N_RD; i++)
                check($sformatf("rd%0d", i), {32'd0, rd(i)}, {32'd0, exp_rd(i)});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clear_req = 1'b0;
        bus.wr_en     = '0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rd_addr   = '0;
    endtask

    task automatic set_wr(input int p, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.wr_en[p]                    = 1'b1;
        bus.wr_addr[p*ADDR_W +: ADDR_W] = a;
        bus.wr_data[p*DATA_W +: DATA_W] = d;
    endtask

    task automatic set_rd(input int i, input logic [ADDR_W-1:0] a);
        bus.rd_addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.ready && n < 100) begin
            tick();
            n++;
        end
    endtask

    int n;

    initial begin
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", {63'd0, bus.ready}, 64'd0);
        check("rst_rd0", {32'd0, rd(0)}, 64'd0);
        wait_ready(n);
        check("first_sweep_len", n, 64'd32);

        // Reset sweep wipes a preloaded register.
        set_wr(0, 5'd7, 32'hDEADBEEF);
        tick();
        idle_inputs();
        set_rd(0, 5'd7);
        #1 check("preload7", {32'd0, rd(0)}, 64'hDEADBEEF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_ready_low", {63'd0, bus.ready}, 64'd0);
        wait_ready(n);
        check("reset_sweep_len", n, 64'd32);
        #1 check("reg7_cleared", {32'd0, rd(0)}, 64'd0);

        // Basic write then read.
        idle_inputs();
        set_wr(0, 5'd3, 32'h12345678);
        tick();
        idle_inputs();
        set_rd(0, 5'd3);
        set_rd(1, 5'd0);
        #1 check("basic_rd0", {32'd0, rd(0)}, 64'h12345678);
        check("basic_rd1_zero", {32'd0, rd(1)}, 64'd0);

        // Two ports on one address: port 1 wins.
        set_wr(0, 5'd5, 32'hAAAA0000);
        set_wr(1, 5'd5, 32'h5555FFFF);
        tick();
        idle_inputs();
        set_rd(0, 5'd5);
        #1 check("conflict", {32'd0, rd(0)}, 64'h5555FFFF);

        // Writes to register 0 are dropped.
        idle_inputs();
        set_wr(1, 5'd0, 32'hFFFFFFFF);
        tick();
        bus.wr_en = '0;
        for (int k = 0; k < 3; k++) begin
            #1 check("zero_reg_rd0", {32'd0, rd(0)}, 64'd0);
            check("zero_reg_rd1", {32'd0, rd(1)}, 64'd0);
            tick();
        end

        // Same-cycle read of a register being written.
        idle_inputs();
        set_wr(0, 5'd9, 32'hCAFEF00D);
        set_rd(0, 5'd9);
`ifdef REGFILE_BYPASS_EN
        #1 check("bypass_same_cycle", {32'd0, rd(0)}, 64'hCAFEF00D);
`else
        #1 check("no_bypass_same_cycle", {32'd0, rd(0)}, 64'd0);
`endif
        tick();
        idle_inputs();
        set_rd(0, 5'd9);
        #1 check("write_visible_next", {32'd0, rd(0)}, 64'hCAFEF00D);

        // clear_req at sweep cycle 10 restarts the sweep; writes during it are lost.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        set_wr(0, 5'd12, 32'h11111111);
        set_wr(1, 5'd13, 32'h22222222);
        wait_ready(n);
        check("restart_sweep_len", n, 64'd32);
        idle_inputs();
        set_rd(0, 5'd12);
        set_rd(1, 5'd13);
        #1 check("sweep_write12_gone", {32'd0, rd(0)}, 64'd0);
        check("sweep_write13_gone", {32'd0, rd(1)}, 64'd0);

        // clear_req in IDLE discards the same-cycle write.
        set_wr(0, 5'd20, 32'h0BADF00D);
        bus.clear_req = 1'b1;
        tick();
        idle_inputs();
        check("idle_clear_ready_low", {63'd0, bus.ready}, 64'd0);
        wait_ready(n);
        check("idle_clear_sweep_len", n, 64'd32);
        set_rd(0, 5'd20);
        #1 check("idle_clear_write_gone", {32'd0, rd(0)}, 64'd0);

        // Randomized traffic, checked every cycle by the model compare process.
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 499) == 0);
            bus.clear_req = ($urandom_range(0, 199) == 0);
            for (int p = 0; p < N_WR; p++) begin
                bus.wr_en[p] = 1'($urandom_range(0, 1));
                bus.wr_addr[p*ADDR_W +: ADDR_W] = ($urandom_range(0, 3) == 0) ?
                    ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
                bus.wr_data[p*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
            for (int i = 0; i < N_RD; i++) begin
                if ($urandom_range(0, 1) == 0)
                    set_rd(i, bus.wr_addr[($urandom_range(0, N_WR-1))*ADDR_W +: ADDR_W]);
                else
                    set_rd(i, ADDR_W'($urandom));
            end
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
